wrp_shff_arb: RTL and testbench
===============================

Name: wrp_shff_arb

Overview:
Round-robin burst arbiter that shares one shuffle output FIFO write port (fifo_we/fifo_wd/fifo_af) between NREQ 64-bit shuffle-stage requesters. A grant locks onto one requester for BURST_LEN accepted words, so each requester's data reaches the AXI output contiguously in bursts. Sits between the shuffle engines and the FIFO-to-AXI stream wrapper, and honours the wrapper's prog_full backpressure.

Parameters:
NREQ, 4, number of requesters (2..16)
BURST_LEN, 16, words per grant (>=1); must not exceed the FIFO headroom above the prog_full threshold (48 for the 64-deep / threshold-16 wrapper)
CNT_W, 32, width of the per-requester statistics counters (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_vld  in  NREQ  per-requester word valid
s_dat  in  NREQ*64  per-requester word; requester i occupies bits [64*i+63:64*i]
s_rdy  out  NREQ  per-requester ready (combinational)
fifo_af  in  1  prog_full from the downstream FIFO wrapper
fifo_we  out  1  FIFO write enable (registered)
fifo_wd  out  64  FIFO write data (registered)
gnt  out  NREQ  one-hot current grant (registered); all zero when idle
busy  out  1  high in state BURST
stat_cnt  out  NREQ*CNT_W  per-requester accepted-word counters (only when WRP_SHFF_ARB_STAT_EN is defined)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; gnt=0; busy=0; fifo_we=0; fifo_wd=0; rr_ptr=0; beat counter=0; stat_cnt=0.
- State machine: IDLE and BURST.
- IDLE: if fifo_af=0 and any s_vld bit is set, grant the first requester with s_vld=1, searching upward from rr_ptr with wrap at NREQ. Next cycle: gnt is one-hot for that requester, state=BURST, beat counter=0. If fifo_af=1, hold IDLE and issue no grant.
- BURST: s_rdy[i] = gnt[i] & ~fifo_af. All other s_rdy bits are 0, and all s_rdy bits are 0 in IDLE.
- Beat: accepted when s_vld[g] & s_rdy[g]. The following cycle, fifo_we=1 and fifo_wd equals that word (latency 1). Otherwise fifo_we=0 and fifo_wd holds its previous value.
- The grant stays locked while the requester drops s_vld or while fifo_af=1. There is no timeout, and the burst never abandons an owner.
- Beat counter width is clog2(BURST_LEN) (minimum 1). On the beat with counter=BURST_LEN-1: next state=IDLE, gnt=0, rr_ptr=(g+1) mod NREQ. The next grant can then issue the cycle after.
- One bubble cycle separates back-to-back bursts, so peak throughput is BURST_LEN/(BURST_LEN+1).
- fifo_af is sampled combinationally each cycle. The FIFO wrapper adds one input register, so at most 2 words land after af rises; BURST_LEN headroom covers this.
- rst_n asserted mid-burst: the burst is dropped immediately, with no fifo_we pulse for the word in flight.
- Beat counter: BURST_LEN=1 gives one word per grant with strict round-robin.

Optional Feature:
WRP_SHFF_ARB_STAT_EN
- Defined: the stat_cnt port exists. Counter i increments on every accepted beat from requester i and saturates at 2^CNT_W-1. Reset clears it to 0.
- Not defined: the stat_cnt port and its counters are absent; all other behaviour is identical.

Test Plan:
- Single requester: s_vld[0]=1 continuously with data 0..15, fifo_af=0 -> gnt=0001 from cycle 1; 16 fifo_we pulses, fifo_wd=0..15, one cycle after each beat; IDLE after beat 15.
- All four requesters valid, BURST_LEN=16 -> grant order 0,1,2,3,0; each burst is 16 consecutive words; 1 idle cycle between bursts; 68 cycles per round.
- fifo_af=1 for 5 cycles during beat 7 of a burst -> s_rdy=0 and no fifo_we for those 5 cycles (after the 1-cycle write of beat 7); resumes at beat 8 with gnt unchanged.
- fifo_af=1 while idle with s_vld=1111 -> gnt stays 0000 and no writes; af falls -> grant to requester rr_ptr.
- s_vld[2] drops for 3 cycles mid-burst while s_vld[3]=1 -> gnt stays 0100 and requester 3 is not served until requester 2 completes 16 beats.
- rst_n low at beat 9 -> gnt, fifo_we and stat_cnt are 0 immediately; after release, the first grant goes to requester 0. With WRP_SHFF_ARB_STAT_EN, 2 full bursts on requester 1 -> stat_cnt[1]=32.

Source files
------------

// File: rtl/wrp_shff_arb.sv
// Round-robin burst arbiter that merges NREQ 64-bit shuffle streams into one FIFO write port.
// Define WRP_SHFF_ARB_STAT_EN to add the per-requester saturating stat_cnt counters.
//   state    | meaning
//   ST_IDLE  | no owner; searching upward from rr_ptr for a valid requester
//   ST_BURST | locked to own_q until BURST_LEN words are accepted
module wrp_shff_arb #(
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      s_vld,
    input  logic [NREQ*64-1:0]   s_dat,
    output logic [NREQ-1:0]      s_rdy,
    input  logic                 fifo_af,
    output logic                 fifo_we,
    output logic [63:0]          fifo_wd,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy
`ifdef WRP_SHFF_ARB_STAT_EN
    ,
    output logic [NREQ*CNT_W-1:0] stat_cnt
`endif
);

    localparam int BC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PTR_W = $clog2(NREQ);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NREQ - 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [PTR_W-1:0]  own_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [BC_W-1:0]   bcnt_q;
    logic              fifo_we_q;
    logic [63:0]       fifo_wd_q;

    logic              found;
    logic [PTR_W-1:0]  sel;
    logic [NREQ-1:0]   sel_oh;
    logic [PTR_W-1:0]  rr_nxt;
    logic              acc;
    logic [63:0]       own_dat;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && s_vld[idx]) begin
                found = 1'b1;
                sel   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    // gnt_q is all-zero in IDLE, so this also blocks every requester there.
    assign s_rdy   = gnt_q & {NREQ{~fifo_af}};
    assign acc     = |(s_vld & s_rdy);
    assign own_dat = s_dat[{own_q, 6'd0} +: 64];
    assign rr_nxt  = (own_q == PTR_MAX) ? '0 : own_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            own_q     <= '0;
            rr_ptr_q  <= '0;
            bcnt_q    <= '0;
            fifo_we_q <= 1'b0;
            fifo_wd_q <= '0;
        end else begin
            fifo_we_q <= acc;
            if (acc) fifo_wd_q <= own_dat;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_af && found) begin
                        state_q <= ST_BURST;
                        gnt_q   <= sel_oh;
                        own_q   <= sel;
                        bcnt_q  <= '0;
                    end
                end
                ST_BURST: begin
                    if (acc) begin
                        if (bcnt_q == BC_LAST) begin
                            state_q  <= ST_IDLE;
                            gnt_q    <= '0;
                            rr_ptr_q <= rr_nxt;
                            bcnt_q   <= '0;
                        end else begin
                            bcnt_q <= bcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_we = fifo_we_q;
    assign fifo_wd = fifo_wd_q;
    assign gnt     = gnt_q;
    assign busy    = (state_q == ST_BURST);

`ifdef WRP_SHFF_ARB_STAT_EN
    logic [CNT_W-1:0] stat_q [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (s_vld[i] && s_rdy[i] && !(&stat_q[i])) stat_q[i] <= stat_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++) stat_cnt[i*CNT_W +: CNT_W] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_wrp_shff_arb.sv
// Directed bench for wrp_shff_arb (NREQ=4, BURST_LEN=16); lane i sends {i, running word count}.
module tb_wrp_shff_arb;

    localparam int NREQ  = 4;
    localparam int CNT_W = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     s_vld;
    logic [NREQ*64-1:0]  s_dat;
    logic [NREQ-1:0]     s_rdy;
    logic                fifo_af;
    logic                fifo_we;
    logic [63:0]         fifo_wd;
    logic [NREQ-1:0]     gnt;
    logic                busy;
`ifdef WRP_SHFF_ARB_STAT_EN
    logic [NREQ*CNT_W-1:0] stat_cnt;
`endif

    wrp_shff_arb #(.NREQ(NREQ), .BURST_LEN(16), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_vld   (s_vld),
        .s_dat   (s_dat),
        .s_rdy   (s_rdy),
        .fifo_af (fifo_af),
        .fifo_we (fifo_we),
        .fifo_wd (fifo_wd),
        .gnt     (gnt),
        .busy    (busy)
`ifdef WRP_SHFF_ARB_STAT_EN
        ,
        .stat_cnt(stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [55:0] cnt [NREQ];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) if (s_vld[i] && s_rdy[i]) cnt[i] <= cnt[i] + 1'b1;
        end
    end

    always_comb begin
        s_dat = '0;
        for (int i = 0; i < NREQ; i++) s_dat[64*i +: 64] = {8'(i), cnt[i]};
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_vld   = '0;
        fifo_af = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'd1;
        return one << i;
    endfunction

    function automatic logic [63:0] word(input int lane, input int n);
        return {8'(lane), 56'(n)};
    endfunction

    typedef struct {
        logic [3:0]  vld;
        logic        af;
        logic [3:0]  gnt;
        logic        we;
        logic [63:0] wd;
        logic [3:0]  rdy;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int pos, r;

        // single requester: grant at cycle 1, words 0..15, idle, regrant to 0
        for (int k = 1; k <= 18; k++) begin
            tbl[k-1].vld = 4'b0001;
            tbl[k-1].af  = 1'b0;
            tbl[k-1].gnt = (k <= 16 || k == 18) ? 4'b0001 : 4'b0000;
            tbl[k-1].we  = (k >= 2 && k <= 17);
            tbl[k-1].wd  = (k == 1) ? 64'd0 : (k == 18) ? 64'd15 : 64'(k - 2);
            tbl[k-1].rdy = tbl[k-1].gnt;
        end

        rst_n   = 1'b0;
        s_vld   = '0;
        fifo_af = 1'b0;
        #2;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_we", 64'(fifo_we), 64'd0);
        chk("rst_wd", fifo_wd, 64'd0);
        chk("rst_rdy", 64'(s_rdy), 64'd0);

        do_reset();
        for (int k = 0; k < 18; k++) begin
            s_vld   = tbl[k].vld;
            fifo_af = tbl[k].af;
            step();
            chk($sformatf("t1_gnt[%0d]", k + 1), 64'(gnt), 64'(tbl[k].gnt));
            chk($sformatf("t1_we[%0d]", k + 1), 64'(fifo_we), 64'(tbl[k].we));
            chk($sformatf("t1_wd[%0d]", k + 1), fifo_wd, tbl[k].wd);
            chk($sformatf("t1_rdy[%0d]", k + 1), 64'(s_rdy), 64'(tbl[k].rdy));
            chk($sformatf("t1_busy[%0d]", k + 1), 64'(busy), 64'(tbl[k].gnt != 0));
        end

        // all four valid: order 0,1,2,3,0 with a one-cycle bubble, 68 cycles per round
        do_reset();
        s_vld = 4'b1111;
        for (int c = 1; c <= 69; c++) begin
            step();
            pos = (c - 1) % 17;
            r   = ((c - 1) / 17) % 4;
            chk($sformatf("t2_gnt[%0d]", c), 64'(gnt), 64'((pos <= 15) ? oh(r) : 4'b0000));
            chk($sformatf("t2_we[%0d]", c), 64'(fifo_we), 64'(pos >= 1));
            if (pos >= 1) chk($sformatf("t2_wd[%0d]", c), fifo_wd, word(r, pos - 1));
        end

        // prog_full for 5 cycles right after beat 7 is accepted
        do_reset();
        s_vld = 4'b0001;
        step();
        chk("t3_gnt_start", 64'(gnt), 64'h1);
        repeat (8) step();
        chk("t3_we_b7", 64'(fifo_we), 64'd1);
        chk("t3_wd_b7", fifo_wd, 64'd7);
        fifo_af = 1'b1;
        #1;
        chk("t3_rdy_af", 64'(s_rdy), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t3_we_af[%0d]", k), 64'(fifo_we), 64'd0);
            chk($sformatf("t3_gnt_af[%0d]", k), 64'(gnt), 64'h1);
            chk($sformatf("t3_rdy_af[%0d]", k), 64'(s_rdy), 64'd0);
        end
        fifo_af = 1'b0;
        for (int j = 8; j <= 15; j++) begin
            step();
            chk($sformatf("t3_we[%0d]", j), 64'(fifo_we), 64'd1);
            chk($sformatf("t3_wd[%0d]", j), fifo_wd, 64'(j));
            chk($sformatf("t3_gnt[%0d]", j), 64'(gnt), (j < 15) ? 64'h1 : 64'h0);
        end

        // prog_full while idle holds off every grant
        do_reset();
        fifo_af = 1'b1;
        s_vld   = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t4_gnt[%0d]", k), 64'(gnt), 64'd0);
            chk($sformatf("t4_we[%0d]", k), 64'(fifo_we), 64'd0);
            chk($sformatf("t4_rdy[%0d]", k), 64'(s_rdy), 64'd0);
        end
        fifo_af = 1'b0;
        step();
        chk("t4_gnt_release", 64'(gnt), 64'h1);

        // owner drops valid mid-burst; the lock holds and requester 3 waits
        do_reset();
        s_vld = 4'b1100;
        step();
        chk("t5_gnt_start", 64'(gnt), 64'h4);
        repeat (3) step();
        chk("t5_wd_b2", fifo_wd, word(2, 2));
        s_vld = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t5_gnt_gap[%0d]", k), 64'(gnt), 64'h4);
            chk($sformatf("t5_we_gap[%0d]", k), 64'(fifo_we), 64'd0);
            chk($sformatf("t5_rdy_gap[%0d]", k), 64'(s_rdy), 64'h4);
        end
        s_vld = 4'b1100;
        for (int j = 3; j <= 15; j++) begin
            step();
            chk($sformatf("t5_we[%0d]", j), 64'(fifo_we), 64'd1);
            chk($sformatf("t5_wd[%0d]", j), fifo_wd, word(2, j));
            chk($sformatf("t5_gnt[%0d]", j), 64'(gnt), (j < 15) ? 64'h4 : 64'h0);
        end
        step();
        chk("t5_gnt_next", 64'(gnt), 64'h8);

        // asynchronous reset while beat 9 is pending
        do_reset();
        s_vld = 4'b0001;
        step();
        repeat (9) step();
        chk("t6_wd_b8", fifo_wd, 64'd8);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_gnt", 64'(gnt), 64'd0);
        chk("t6_we", 64'(fifo_we), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_wd", fifo_wd, 64'd0);
`ifdef WRP_SHFF_ARB_STAT_EN
        chk("t6_stat", 64'(stat_cnt[0 +: CNT_W]), 64'd0);
`endif
        #1;
        rst_n = 1'b1;
        s_vld = 4'b1111;
        step();
        chk("t6_gnt_after", 64'(gnt), 64'h1);

`ifdef WRP_SHFF_ARB_STAT_EN
        // two full bursts on requester 1
        do_reset();
        s_vld = 4'b0010;
        repeat (34) step();
        chk("t7_stat1", 64'(stat_cnt[1*CNT_W +: CNT_W]), 64'd32);
        chk("t7_stat0", 64'(stat_cnt[0 +: CNT_W]), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
